exins_responder: RTL and testbench
==================================

EXINS_RESPONDER -- requirements
Module: exins_responder

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width (memory depth 2^AW words of 32 bits).
REQ-002 SHALL have parameter LAT, default 1, range 0..15, meaning wait cycles between request accept and response.
REQ-003 SHALL have parameter NOP, default 32'h00000013, meaning instruction returned on an erroneous fetch.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port exIns_ren  input  1  fetch request from the core, level-sensitive.
REQ-007 SHALL have port exIns_addr  input  32  fetch byte address.
REQ-008 SHALL have port exIns_valid  output  1  one-cycle strobe; exIns_in holds the fetched word.
REQ-009 SHALL have port exIns_in  output  32  fetched instruction.
REQ-010 SHALL have port busy  output  1  high while a request is outstanding (state WAIT).
REQ-011 SHALL have port ld_mode  input  1  loader mode; fetches blocked, loads enabled.
REQ-012 SHALL have port ld_en  input  1  loader write strobe.
REQ-013 SHALL have port ld_addr  input  AW  loader word address.
REQ-014 SHALL have port ld_data  input  32  loader write data.
REQ-015 SHALL have port err  output  1  sticky error flag.
REQ-016 SHALL have port err_clr  input  1  synchronous clear of err.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL accept a request in any cycle with exIns_ren=1, ld_mode=0 and state IDLE or RESP; the address is captured at that edge.
REQ-019 SHALL, on accept, load the wait counter with LAT and go to WAIT if LAT>0, otherwise go directly to RESP.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-021 SHALL assert exIns_valid for exactly the single cycle spent in RESP, i.e. LAT+1 cycles after the accept edge.
REQ-022 SHALL, in RESP, accept a new request if exIns_ren=1 (back-to-back: one response per LAT+1 cycles); otherwise return to IDLE.
REQ-023 SHALL ignore exIns_ren while in WAIT, with no queuing.
REQ-024 SHALL drive exIns_in = mem[addr[AW+1:2]], reading the array at the edge entering RESP.
REQ-025 SHALL hold exIns_in at its last value when exIns_valid=0.
REQ-026 SHALL return NOP and set err when the captured address has addr[1:0]!=0 or addr[31:AW+2]!=0.
REQ-027 SHALL write ld_data to mem[ld_addr] at the clock edge when ld_mode=1 and ld_en=1; ld_en SHALL be ignored when ld_mode=0.
REQ-028 SHALL complete an outstanding request normally if ld_mode rises during WAIT, but SHALL accept no new request while ld_mode=1.
REQ-029 SHALL give err_clr priority over a simultaneous err set (err=0 after that edge).
REQ-030 SHALL NOT reset or initialise the memory array.

Reset
REQ-031 SHALL, while nrst=0, force state IDLE, counter 0, exIns_valid=0, exIns_in=32'h0, busy=0, err=0, independently of clk.
REQ-032 SHALL discard any outstanding request when nrst is asserted mid-operation; no response is issued after release.
REQ-033 SHALL accept a request on the first rising edge after nrst deasserts.

Verification
REQ-034 SHALL pass this test: LAT=1, load mem[4]=32'h00A00093, then exIns_ren=1, addr=32'h10 for one cycle -> exIns_valid high exactly 2 cycles after accept, exIns_in=32'h00A00093, busy high for 1 cycle.
REQ-035 SHALL pass this test: LAT=0, exIns_ren held high with addresses 0,4,8 -> valid on 3 consecutive cycles returning mem[0],mem[1],mem[2].
REQ-036 SHALL pass this test: fetch addr=32'h6 -> exIns_in=32'h00000013, err=1; then err_clr together with a fresh misaligned response -> err=0.
REQ-037 SHALL pass this test: LAT=3, nrst pulsed low during WAIT -> exIns_valid stays 0 and no response is issued afterwards.
REQ-038 SHALL pass this test: ld_mode=1 with exIns_ren=1 -> no accept and valid=0; ld_en=1 with ld_mode=0 -> memory unchanged.

Source files
------------

// File: rtl/exins_responder.sv
`default_nettype none
// ============================================================================
// Module      : exins_responder
// Description : Instruction-fetch responder backed by a loadable word memory.
//               It answers each accepted fetch after LAT wait cycles and
//               returns NOP with a sticky error on a bad address.
// Revision    : 1.0 - initial release
// ============================================================================
module exins_responder #(
    parameter int          AW  = 10,
    parameter int          LAT = 1,
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          exIns_ren,
    input  logic [31:0]   exIns_addr,
    output logic          exIns_valid,
    output logic [31:0]   exIns_in,
    output logic          busy,
    input  logic          ld_mode,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          err,
    input  logic          err_clr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;
    localparam logic [3:0] c_LAT   = 4'(LAT);
    localparam int         c_DEPTH = 1 << AW;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] r_mem [0:c_DEPTH-1];

    logic        w_accept;
    logic        w_enter_resp;
    logic [31:0] w_rd_addr;
    logic        w_rd_bad;

    assign w_accept = exIns_ren && !ld_mode &&
                      ((r_state == c_IDLE) || (r_state == c_RESP));

    // With LAT=0 the response is formed at the accept edge itself, so the
    // live address must feed the read; otherwise the captured one is used.
    assign w_rd_addr    = w_accept ? exIns_addr : r_addr;
    assign w_rd_bad     = (w_rd_addr[1:0] != 2'b00) ||
                          ((w_rd_addr >> (AW + 2)) != 32'd0);
    assign w_enter_resp = (w_next_state == c_RESP);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = (c_LAT == 4'd0) ? c_RESP : c_WAIT;
        end else begin
            case (r_state)
                c_IDLE:  w_next_state = c_IDLE;
                c_WAIT:  w_next_state = (r_cnt == 4'd1) ? c_RESP : c_WAIT;
                c_RESP:  w_next_state = c_IDLE;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        exIns_valid = (r_state == c_RESP);
        busy        = (r_state == c_WAIT);
    end

    assign exIns_in = r_data;
    assign err      = r_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt  <= 4'd0;
            r_addr <= 32'd0;
            r_data <= 32'd0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt  <= c_LAT;
                r_addr <= exIns_addr;
            end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_data <= w_rd_bad ? NOP : r_mem[w_rd_addr[AW+1:2]];
            end

            if (err_clr) begin
                r_err <= 1'b0;
            end else if (w_enter_resp && w_rd_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Memory contents are deliberately left unreset; only the loader writes.
    always_ff @(posedge clk) begin
        if (ld_mode && ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exins_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_exins_responder
// Description : Directed self-checking bench; three instances at LAT=0/1/3
//               share stimulus, each test checks the instance it targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exins_responder;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        exIns_ren = 1'b0;
    logic [31:0] exIns_addr = 32'd0;
    logic        ld_mode = 1'b0;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = 10'd0;
    logic [31:0] ld_data = 32'd0;
    logic        err_clr = 1'b0;

    logic        valid0, valid1, valid3;
    logic [31:0] data0, data1, data3;
    logic        busy0, busy1, busy3;
    logic        err0, err1, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exins_responder #(.AW(10), .LAT(0), .NOP(32'h00000013)) dut0 (
        .clk(clk), .nrst(nrst), .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(valid0), .exIns_in(data0), .busy(busy0), .ld_mode(ld_mode),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err0),
        .err_clr(err_clr)
    );

    exins_responder #(.AW(10), .LAT(1), .NOP(32'h00000013)) dut1 (
        .clk(clk), .nrst(nrst), .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(valid1), .exIns_in(data1), .busy(busy1), .ld_mode(ld_mode),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err1),
        .err_clr(err_clr)
    );

    exins_responder #(.AW(10), .LAT(3), .NOP(32'h00000013)) dut3 (
        .clk(clk), .nrst(nrst), .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(valid3), .exIns_in(data3), .busy(busy3), .ld_mode(ld_mode),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err3),
        .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        exIns_ren = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        ld_mode = 1'b1;
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        ld_mode = 1'b0;
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        #2;
        checks++;
        if ({valid1, busy1, err1} !== 3'b000 || data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: valid/busy/err=%b data=%h expected 000 00000000",
                     {valid1, busy1, err1}, data1);
        end
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_load_fetch();
        load_word(10'd4, 32'h00A00093);
        exIns_ren  = 1'b1;
        exIns_addr = 32'h10;
        tick();
        exIns_ren = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: busy=%b valid=%b expected 1 0", busy1, valid1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b1 || busy1 !== 1'b0 || data1 !== 32'h00A00093) begin
            errors++;
            $display("FAIL fetch_resp: valid=%b busy=%b data=%h expected 1 0 00a00093",
                     valid1, busy1, data1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b0 || data1 !== 32'h00A00093 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: valid=%b data=%h err=%b expected 0 00a00093 0",
                     valid1, data1, err1);
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h11111111;
        exp[1] = 32'h22222222;
        exp[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) load_word(10'(i), exp[i]);
        exIns_ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exIns_addr = 32'(i * 4);
            tick();
            checks++;
            if (valid0 !== 1'b1 || data0 !== exp[i]) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%b data=%h expected 1 %h", i, valid0, data0, exp[i]);
            end
        end
        exIns_ren = 1'b0;
        tick();
        checks++;
        if (valid0 !== 1'b0 || data0 !== 32'h33333333) begin
            errors++;
            $display("FAIL b2b_end: valid=%b data=%h expected 0 33333333", valid0, data0);
        end
        idle(5);
    endtask

    task automatic test_misaligned();
        exIns_ren  = 1'b1;
        exIns_addr = 32'h6;
        tick();
        exIns_ren = 1'b0;
        tick();
        checks++;
        if (valid1 !== 1'b1 || data1 !== 32'h00000013 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL misalign: valid=%b data=%h err=%b expected 1 00000013 1",
                     valid1, data1, err1);
        end
        tick();
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b expected 1", err1);
        end
        exIns_ren  = 1'b1;
        exIns_addr = 32'h6;
        tick();
        exIns_ren = 1'b0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (valid1 !== 1'b1 || data1 !== 32'h00000013 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clr_prio: valid=%b data=%h err=%b expected 1 00000013 0",
                     valid1, data1, err1);
        end
        idle(5);
        exIns_ren  = 1'b1;
        exIns_addr = 32'h1000;
        tick();
        exIns_ren = 1'b0;
        tick();
        checks++;
        if (data1 !== 32'h00000013 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range: data=%h err=%b expected 00000013 1", data1, err1);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b expected 0", err1);
        end
        idle(5);
    endtask

    task automatic test_reset_mid();
        int seen;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h10;
        tick();
        exIns_ren = 1'b0;
        tick();
        checks++;
        if (busy3 !== 1'b1) begin
            errors++;
            $display("FAIL lat3_busy: busy=%b expected 1", busy3);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (busy3 !== 1'b0 || valid3 !== 1'b0 || data3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b data=%h expected 0 0 00000000",
                     busy3, valid3, data3);
        end
        tick();
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid3 !== 1'b0 || busy3 !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_resp_after_reset: active cycles=%0d expected 0", seen);
        end
        nrst = 1'b0;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h10;
        tick();
        nrst = 1'b1;
        tick();
        exIns_ren = 1'b0;
        checks++;
        if (busy3 !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_accept: busy=%b expected 1", busy3);
        end
        tick();
        tick();
        tick();
        checks++;
        if (valid3 !== 1'b1 || data3 !== 32'h00A00093) begin
            errors++;
            $display("FAIL lat3_resp: valid=%b data=%h expected 1 00a00093", valid3, data3);
        end
        idle(5);
    endtask

    task automatic test_loader_block();
        ld_mode    = 1'b1;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h10;
        tick();
        checks++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL ldmode_block: busy=%b valid=%b expected 0 0", busy1, valid1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL ldmode_novalid: valid1=%b valid0=%b expected 0 0", valid1, valid0);
        end
        exIns_ren = 1'b0;
        ld_mode   = 1'b0;
        ld_en     = 1'b1;
        ld_addr   = 10'd4;
        ld_data   = 32'hDEADBEEF;
        tick();
        ld_en = 1'b0;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h10;
        tick();
        exIns_ren = 1'b0;
        ld_mode   = 1'b1;
        tick();
        checks++;
        if (valid1 !== 1'b1 || data1 !== 32'h00A00093) begin
            errors++;
            $display("FAIL ld_en_ignored: valid=%b data=%h expected 1 00a00093", valid1, data1);
        end
        tick();
        tick();
        checks++;
        if (valid3 !== 1'b1 || data3 !== 32'h00A00093) begin
            errors++;
            $display("FAIL ldmode_during_wait: valid=%b data=%h expected 1 00a00093",
                     valid3, data3);
        end
        ld_mode = 1'b0;
        idle(5);
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        test_loader_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
